core_lsu: RTL and testbench

Parametrised load-store unit between the core's datapath and data memory. It replaces the combinational single-cycle memory port with a registered request/ready handshake. It also provides byte-lane alignment, sign/zero extension, misalignment detection, a wait-state timeout, and a stall output that freezes the core's PC while an access is outstanding.

---
 rtl/core_lsu_pkg.sv | 32 +++
 rtl/core_lsu_if.sv | 18 +
 rtl/core_lsu_align.sv | 60 ++++++
 rtl/core_lsu.sv | 124 ++++++++++++
 tb/tb_core_lsu.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_lsu_pkg.sv
// rtl/core_lsu_pkg.sv - shared types and helpers for the load-store unit
package lsu_pkg;

  // RISC-V funct3 access sizes
  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_D  = 3'd3,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5,
    SZ_WU = 3'd6
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-enable mask of an access at lane 0; zero for an unknown size
  function automatic logic [7:0] base_mask(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: base_mask = 8'h01;
      SZ_H, SZ_HU: base_mask = 8'h03;
      SZ_W, SZ_WU: base_mask = 8'h0F;
      SZ_D:        base_mask = 8'hFF;
      default:     base_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// rtl/core_lsu_if.sv - data-memory request/ready bus
interface core_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W-1:0]     rd;
  logic                  ready;

  modport master (output req, we, be, addr, wd, input rd, ready);
  modport slave  (input req, we, be, addr, wd, output rd, ready);

endinterface

// File: rtl/core_lsu_align.sv
// rtl/core_lsu_align.sv - byte-lane legality, enables, store shift and load extension
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [2:0]                  size_i,
  input  logic [DATA_W-1:0]           wd_i,
  output logic                        legal_o,
  output logic [DATA_W/8-1:0]         be_o,
  output logic [DATA_W-1:0]           wd_o,
  input  logic [$clog2(DATA_W/8)-1:0] rd_off_i,
  input  logic [2:0]                  rd_size_i,
  input  logic [DATA_W-1:0]           rd_i,
  output logic [DATA_W-1:0]           rd_o
);

  localparam int BE_W = DATA_W / 8;

  logic [7:0]        mask;
  logic [DATA_W-1:0] rd_sh;

  // Natural alignment per size; 64-bit-only sizes are rejected on a 32-bit bus
  always_comb begin
    legal_o = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: legal_o = 1'b1;
      SZ_H, SZ_HU: legal_o = (off_i[0] == 1'b0);
      SZ_W:        legal_o = (off_i[1:0] == 2'b00);
      SZ_WU:       legal_o = (DATA_W == 64) && (off_i[1:0] == 2'b00);
      SZ_D:        legal_o = (DATA_W == 64) && (off_i == '0);
      default:     legal_o = 1'b0;
    endcase
  end

  // Move the size mask and the store data up to the addressed lane
  always_comb begin
    mask = base_mask(size_i);
    be_o = mask[BE_W-1:0] << off_i;
    wd_o = wd_i << {off_i, 3'b000};
  end

  // Bring the addressed lane down to bit 0 and extend it to full width
  always_comb begin
    rd_sh = rd_i >> {rd_off_i, 3'b000};
    rd_o  = '0;
    case (rd_size_i)
      SZ_B:    rd_o = DATA_W'($signed(rd_sh[7:0]));
      SZ_BU:   rd_o = DATA_W'(rd_sh[7:0]);
      SZ_H:    rd_o = DATA_W'($signed(rd_sh[15:0]));
      SZ_HU:   rd_o = DATA_W'(rd_sh[15:0]);
      SZ_W:    rd_o = DATA_W'($signed(rd_sh[31:0]));
      SZ_WU:   rd_o = DATA_W'(rd_sh[31:0]);
      SZ_D:    rd_o = rd_sh;
      default: rd_o = '0;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - registered load-store unit with timeout and core stall
module core_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              misalign_o,
  output logic              fault_o,
  core_lsu_if.master        mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rd_q;
  logic [2:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mis_q;

  logic [OFF_W-1:0]  off;
  logic              legal;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wd_sh;
  logic [DATA_W-1:0] rd_ext;
  logic              busy;
  logic              timeout_hit;

  assign off  = core_addr_i[OFF_W-1:0];
  assign busy = (state_q == BUSY);

  // Legality and lane steering use the live request; extension uses the captured lane
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .off_i     (off),
    .size_i    (core_size_i),
    .wd_i      (core_wd_i),
    .legal_o   (legal),
    .be_o      (be),
    .wd_o      (wd_sh),
    .rd_off_i  (off_q),
    .rd_size_i (size_q),
    .rd_i      (mem.rd),
    .rd_o      (rd_ext)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next state: a legal request goes to memory, an illegal one answers at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_i) state_d = legal ? BUSY : DONE;
      BUSY:    if (mem.ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus request capture, wait counter and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (core_req_i) begin
          addr_q <= {core_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          we_q   <= core_we_i;
          be_q   <= be;
          wd_q   <= wd_sh;
          size_q <= core_size_i;
          off_q  <= off;
          cnt_q  <= '0;
          rd_q   <= '0;
          mis_q  <= ~legal;
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem.ready && !we_q) rd_q <= rd_ext;
        end
        DONE:    mis_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem.req      = busy;
  assign mem.we       = busy & we_q;
  assign mem.be       = busy ? be_q   : '0;
  assign mem.addr     = busy ? addr_q : '0;
  assign mem.wd       = busy ? wd_q   : '0;

  assign core_rd_o    = rd_q;
  assign core_stall_o = core_req_i & (state_q != DONE);
  assign misalign_o   = (state_q == DONE) & mis_q;
  assign fault_o      = busy & ~mem.ready & timeout_hit;

endmodule

// File: tb/tb_core_lsu.sv
// tb/tb_core_lsu.sv - scoreboard bench for core_lsu at 32 and 64 bits
module tb_core_lsu;

  typedef struct packed {
    logic [63:0] rd;
    logic [63:0] wd;
    logic [31:0] addr;
    logic [7:0]  be;
    logic        we;
    logic        mis;
    logic        flt;
    logic        issued;
    int          stall;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          w;
  } stim_t;

  logic clk;
  int   errors;
  int   checks;
  bit   fin [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Expected outcome of one access from the size/alignment rules and memory wait count
  function automatic exp_t model(input int dw, input int to, input logic we, input logic [2:0] sz,
                                 input logic [31:0] addr, input logic [63:0] wd,
                                 input logic [63:0] rd, input int w);
    exp_t e;
    int nb, lanes, off;
    logic [63:0] dmask, v, fmask;
    e = '0;
    case (sz)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2, 3'd6: nb = 4;
      3'd3:       nb = 8;
      default:    nb = 0;
    endcase
    lanes = dw / 8;
    off   = int'(addr[2:0]) % lanes;
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (nb == 0 || nb > lanes || (sz == 3'd6 && dw == 32) || (off % nb) != 0) begin
      e.mis   = 1'b1;
      e.stall = 1;
      return e;
    end
    e.issued = 1'b1;
    e.we     = we;
    e.addr   = addr - 32'(off);
    e.be     = 8'(((1 << nb) - 1) << off);
    e.wd     = (wd << (8 * off)) & dmask;
    e.flt    = (to != 0) && (w >= to);
    e.stall  = e.flt ? to + 1 : w + 2;
    if (!we && !e.flt) begin
      v = rd >> (8 * off);
      if (nb < 8) begin
        fmask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & fmask;
        if (sz < 3'd3 && v[8*nb-1]) v = v | ~fmask;
      end
      e.rd = v & dmask;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DW = (g == 0) ? 32 : 64;
    localparam int TO = (g == 0) ? 4 : 16;

    logic          rst;
    logic          core_req, core_we, stall, mis, flt;
    logic [2:0]    core_size;
    logic [31:0]   core_addr;
    logic [DW-1:0] core_wd, core_rd;
    int            wait_cfg;
    logic [63:0]   rd_cfg;
    exp_t          q[$];

    core_lsu_if #(.DATA_W(DW), .ADDR_W(32)) mem_bus ();

    core_lsu #(.DATA_W(DW), .ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .core_req_i   (core_req),
      .core_we_i    (core_we),
      .core_size_i  (core_size),
      .core_addr_i  (core_addr),
      .core_wd_i    (core_wd),
      .core_rd_o    (core_rd),
      .core_stall_o (stall),
      .misalign_o   (mis),
      .fault_o      (flt),
      .mem          (mem_bus)
    );

    // Memory model: answers after wait_cfg wait states
    initial begin
      int busy_cnt;
      busy_cnt      = 0;
      mem_bus.ready = 1'b0;
      mem_bus.rd    = '0;
      forever begin
        @(negedge clk);
        mem_bus.rd = DW'(rd_cfg);
        if (mem_bus.req) begin
          mem_bus.ready = (busy_cnt == wait_cfg);
          busy_cnt++;
        end else begin
          mem_bus.ready = 1'b0;
          busy_cnt = 0;
        end
      end
    end

    // Monitor: gathers bus/pulse/stall observations and scores each completed access
    initial begin
      exp_t        e;
      logic [31:0] m_addr;
      logic [7:0]  m_be;
      logic [63:0] m_wd;
      logic        m_we, m_seen, m_mis, m_flt;
      int          m_stall;
      m_addr = '0; m_be = '0; m_wd = '0; m_we = 1'b0;
      m_seen = 1'b0; m_mis = 1'b0; m_flt = 1'b0; m_stall = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          m_seen = 1'b0; m_mis = 1'b0; m_flt = 1'b0; m_stall = 0;
        end else begin
          if (mem_bus.req && !m_seen) begin
            m_seen = 1'b1;
            m_addr = mem_bus.addr;
            m_be   = 8'(mem_bus.be);
            m_wd   = 64'(mem_bus.wd);
            m_we   = mem_bus.we;
          end
          if (flt) m_flt = 1'b1;
          if (mis) m_mis = 1'b1;
          if ((flt || mis) && q.size() == 0) chk("unexpected_pulse", 64'({flt, mis}), 64'd0);
          if (core_req && stall) m_stall++;
          if (core_req && !stall) begin
            if (q.size() == 0) begin
              chk("unexpected_done", 64'd1, 64'd0);
            end else begin
              e = q.pop_front();
              chk("core_rd", 64'(core_rd), e.rd);
              chk("misalign", 64'(m_mis), 64'(e.mis));
              chk("fault", 64'(m_flt), 64'(e.flt));
              chk("mem_issued", 64'(m_seen), 64'(e.issued));
              chk("stall_cycles", 64'(m_stall), 64'(e.stall));
              if (e.issued) begin
                chk("mem_addr", 64'(m_addr), 64'(e.addr));
                chk("mem_be", 64'(m_be), 64'(e.be));
                chk("mem_wd", m_wd, e.wd);
                chk("mem_we", 64'(m_we), 64'(e.we));
              end
            end
            m_seen = 1'b0; m_mis = 1'b0; m_flt = 1'b0; m_stall = 0;
          end
        end
      end
    end

    // Driver: reset checks, reset mid-access, directed and random accesses
    initial begin
      stim_t s;
      stim_t sl[$];
      int    n;
      bit    done_seen;
      fin[g]    = 1'b0;
      rst       = 1'b1;
      core_req  = 1'b0;
      core_we   = 1'b0;
      core_size = 3'd0;
      core_addr = '0;
      core_wd   = '0;
      wait_cfg  = 0;
      rd_cfg    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 64'(mem_bus.req), 64'd0);
      chk("rst_mem_we_be", 64'({mem_bus.we, mem_bus.be}), 64'd0);
      chk("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
      chk("rst_mem_wd", 64'(mem_bus.wd), 64'd0);
      chk("rst_core_rd", 64'(core_rd), 64'd0);
      chk("rst_flags", 64'({stall, mis, flt}), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // LW held waiting; reset lands in its second BUSY cycle
      @(posedge clk); #1;
      core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h80;
      wait_cfg = 50; rd_cfg = 64'h1111_2222_3333_4444;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; core_req = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_req", 64'(mem_bus.req), 64'd0);
      chk("rst_mid_flags", 64'({mis, flt}), 64'd0);
      repeat (3) @(negedge clk);

      sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'h80, wd: 64'd0, rd: 64'h0000_0000_CAFE_F00D, w: 1});
      if (DW == 32) begin
        sl.push_back('{we: 1'b0, sz: 3'd0, addr: 32'h103, wd: 64'd0, rd: 64'h80AA_BBCC, w: 0});
        sl.push_back('{we: 1'b1, sz: 3'd1, addr: 32'h202, wd: 64'h1234, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd5, addr: 32'h202, wd: 64'd0, rd: 64'h8765_0000, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'h101, wd: 64'd0, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd3, addr: 32'h100, wd: 64'd0, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'h40, wd: 64'd0, rd: 64'h5555_AAAA, w: 100});
        sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'h44, wd: 64'd0, rd: 64'h1234_5678, w: 3});
        sl.push_back('{we: 1'b1, sz: 3'd0, addr: 32'h3, wd: 64'hA5, rd: 64'd0, w: 2});
        sl.push_back('{we: 1'b0, sz: 3'd6, addr: 32'h8, wd: 64'd0, rd: 64'd0, w: 0});
      end else begin
        sl.push_back('{we: 1'b0, sz: 3'd3, addr: 32'h8, wd: 64'd0, rd: 64'h8123_4567_89AB_CDEF, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd6, addr: 32'hC, wd: 64'd0, rd: 64'hF000_0000_1234_5678, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'hC, wd: 64'd0, rd: 64'hF000_0000_1234_5678, w: 1});
        sl.push_back('{we: 1'b1, sz: 3'd3, addr: 32'h10, wd: 64'hDEAD_BEEF_0BAD_F00D, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd3, addr: 32'h4, wd: 64'd0, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd1, addr: 32'h7, wd: 64'd0, rd: 64'd0, w: 0});
        sl.push_back('{we: 1'b0, sz: 3'd2, addr: 32'h20, wd: 64'd0, rd: 64'd1, w: 40});
      end
      for (int i = 0; i < 40; i++) begin
        s.sz   = 3'($urandom_range(0, 7));
        s.we   = 1'($urandom_range(0, 1));
        s.addr = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 2) != 0) s.addr = (s.addr & 32'hFFFF_FFF8) | ($urandom_range(0, 1) != 0 ? 32'h4 : 32'h0);
        s.wd   = {$urandom, $urandom};
        s.rd   = {$urandom, $urandom};
        s.w    = ($urandom_range(0, 9) == 0) ? TO + 5 : int'($urandom_range(0, 3));
        sl.push_back(s);
      end

      foreach (sl[i]) begin
        s = sl[i];
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1 core_req = 1'b0;
        end
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_we   = s.we;
        core_size = s.sz;
        core_addr = s.addr;
        core_wd   = DW'(s.wd);
        rd_cfg    = s.rd;
        wait_cfg  = s.w;
        q.push_back(model(DW, TO, s.we, s.sz, s.addr, s.wd, s.rd, s.w));
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < 200) begin
          @(negedge clk);
          n++;
          done_seen = core_req && !stall;
        end
        if (!done_seen) chk("done_wait_bound", 64'(n), 64'd0);
      end
      @(posedge clk); #1 core_req = 1'b0;
      repeat (3) @(negedge clk);
      fin[g] = 1'b1;
    end
  end

  initial begin
    int k;
    errors = 0;
    checks = 0;
    k = 0;
    while (!(fin[0] && fin[1]) && k < 60000) begin
      @(posedge clk);
      k++;
    end
    if (!(fin[0] && fin[1])) chk("global_timeout", 64'(k), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
